adder_7sd: RTL and testbench
============================

# adder_7sd

Signed 6-bit adder with two-digit seven-segment readout. Adds two two's-complement operands, converts the magnitude of the 7-bit result to two decimal digits (tens, units) and drives two seven-segment digits. The decimal point marks a negative result. It sits between switch/operand inputs and a two-digit display on the board top level.

## Interface
- No parameters.
- `clk` in, 1 bit: single system clock, rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `sayi1` in, 6 bits: operand 1, signed two's complement, range -32..31.
- `sayi2` in, 6 bits: operand 2, signed two's complement, range -32..31.
- `A`, `B`, `C`, `D`, `E`, `F`, `G` out, 2 bits each: segment a..g. Bit [1] drives the tens digit and bit [0] drives the units digit. Active-low: 0 means the segment is lit.
- `DP` out, 1 bit: sign indicator, active-low. 0 means the result is negative.

## Operation
- Sum: sign-extend both operands to 7 bits, then `sum = sayi1 + sayi2`. The sum range is -64..62, so overflow cannot occur.
- Sign: `neg = sum[6]`.
- Magnitude: `mag = neg ? -sum : sum`, 7 bits unsigned, range 0..64.
- Decimal split: `tens = mag / 10` (0..6), `units = mag % 10` (0..9). Any synthesizable method is allowed, such as a comparison/subtract chain or double-dabble.
- Units digit: always displayed, including 0.
- Tens digit: blanked (all segments off) when `tens == 0`, i.e. leading-zero suppression.
- DP: low when `neg` is set, high otherwise. Zero is never shown as negative.
- Segment patterns, listed as the segments lit for each digit. Each output bit is the inverse of "lit".
  - 0: abcdef
  - 1: bc
  - 2: abdeg
  - 3: abcdg
  - 4: bcfg
  - 5: acdfg
  - 6: acdefg
  - 7: abc
  - 8: abcdefg
  - 9: abcdfg
  - Blank: none lit.
- Digit codes 10..15 are unreachable. The decoder maps them to blank.

## Timing
- All outputs are registered. Arithmetic and decoding are combinational from the inputs into the output registers.
- Latency: outputs reflect the `sayi1`/`sayi2` values sampled at rising edge N, valid after edge N.
- No handshake. The block recomputes on every clock edge, and input changes take effect on the next edge.
- Reset (sync, `rst=1` at an edge):
  - `A..G = 2'b11` (both digits blank).
  - `DP = 1` (off).
  - Reset held over several edges keeps the display blank.
- Reset mid-operation: the display blanks at the next edge. The first edge after `rst` falls shows the current inputs. No state other than the output registers exists.
- Simultaneous operand changes: both are sampled at the same edge, so no intermediate sum is ever displayed.

## Structure
- Shared package `seg7_pkg`:
  - 7-bit constants for segment patterns: `SEG_0`..`SEG_9`, `SEG_BLANK`.
  - Output polarity constant `SEG_ACTIVE_LOW = 1`.
- Sub-module `seg7_decoder`:
  - Inputs: 4-bit digit, 1-bit blank.
  - Output: 7-bit active-low segments a..g.
  - Instantiated twice, once for tens and once for units.
- Top level: sign-extend/add, absolute value, binary-to-decimal split, two decoders, bit-slicing into `A..G` (tens to bit 1, units to bit 0), output registers.

## Test plan
- Reset: hold `rst=1` for 2 edges with any inputs -> `A..G=2'b11`, `DP=1`. Release; one edge later the outputs match the current inputs.
- Positive sums:
  - 8 + 20 -> tens 2 (`abdeg`), units 8 (all), `DP=1`.
  - 25 + 18 -> tens 4 (`bcfg`), units 3 (`abcdg`), `DP=1`.
- Mixed signs:
  - 8 + (-20) = -12 -> tens 1 (`bc`), units 2, `DP=0`.
  - 13 + (-2) = 11 -> tens 1, units 1, `DP=1`.
- Extremes:
  - -32 + -32 = -64 -> tens 6, units 4, `DP=0`.
  - 31 + 31 = 62 -> tens 6, units 2, `DP=1`.
- Zero and single digit:
  - 5 + (-5) = 0 -> tens blank, units 0 (`abcdef`), `DP=1`.
  - -3 + 0 = -3 -> tens blank, units 3, `DP=0`.
- Latency: change the operands every cycle -> each output set matches the operands of the previous edge, with no skipped or stale values.

Source files
------------

// File: rtl/seg7_pkg.sv
// Segment patterns shared by the seven-segment decoders.
// Patterns are "lit" masks ordered {a,b,c,d,e,f,g}, a in bit 6.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam bit SEG_ACTIVE_LOW = 1'b1;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to seven-segment decoder with blanking; output {a..g}.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  logic [6:0] lit;

  always_comb begin
    lit = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    lit = SEG_0;
        4'd1:    lit = SEG_1;
        4'd2:    lit = SEG_2;
        4'd3:    lit = SEG_3;
        4'd4:    lit = SEG_4;
        4'd5:    lit = SEG_5;
        4'd6:    lit = SEG_6;
        4'd7:    lit = SEG_7;
        4'd8:    lit = SEG_8;
        4'd9:    lit = SEG_9;
        default: lit = SEG_BLANK;
      endcase
    end
  end

  assign seg = SEG_ACTIVE_LOW ? ~lit : lit;

endmodule

// File: rtl/adder_7sd.sv
// Signed 6-bit adder driving a two-digit seven-segment display.
// Tens digit is leading-zero blanked; DP (active-low) flags a negative sum.
module adder_7sd
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sayi1,
  input  logic [5:0] sayi2,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [1:0] C,
  output logic [1:0] D,
  output logic [1:0] E,
  output logic [1:0] F,
  output logic [1:0] G,
  output logic       DP
);

  logic [6:0] sum;
  logic       neg;
  logic [6:0] mag;
  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] seg_tens;
  logic [6:0] seg_units;

  // Range -64..62 fits in 7 bits, so no overflow handling is needed.
  assign sum = {sayi1[5], sayi1} + {sayi2[5], sayi2};
  assign neg = sum[6];
  assign mag = neg ? 7'(-sum) : sum;

  always_comb begin
    tens  = 4'd0;
    units = 4'(mag);
    if (mag >= 7'd60) begin
      tens  = 4'd6;
      units = 4'(mag - 7'd60);
    end else if (mag >= 7'd50) begin
      tens  = 4'd5;
      units = 4'(mag - 7'd50);
    end else if (mag >= 7'd40) begin
      tens  = 4'd4;
      units = 4'(mag - 7'd40);
    end else if (mag >= 7'd30) begin
      tens  = 4'd3;
      units = 4'(mag - 7'd30);
    end else if (mag >= 7'd20) begin
      tens  = 4'd2;
      units = 4'(mag - 7'd20);
    end else if (mag >= 7'd10) begin
      tens  = 4'd1;
      units = 4'(mag - 7'd10);
    end
  end

  seg7_decoder u_dec_tens (
    .digit (tens),
    .blank (tens == 4'd0),
    .seg   (seg_tens)
  );

  seg7_decoder u_dec_units (
    .digit (units),
    .blank (1'b0),
    .seg   (seg_units)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      A  <= 2'b11;
      B  <= 2'b11;
      C  <= 2'b11;
      D  <= 2'b11;
      E  <= 2'b11;
      F  <= 2'b11;
      G  <= 2'b11;
      DP <= 1'b1;
    end else begin
      A  <= {seg_tens[6], seg_units[6]};
      B  <= {seg_tens[5], seg_units[5]};
      C  <= {seg_tens[4], seg_units[4]};
      D  <= {seg_tens[3], seg_units[3]};
      E  <= {seg_tens[2], seg_units[2]};
      F  <= {seg_tens[1], seg_units[1]};
      G  <= {seg_tens[0], seg_units[0]};
      DP <= ~neg;
    end
  end

endmodule

// File: tb/tb_adder_7sd.sv
// Self-checking bench for adder_7sd: scoreboard of expected displays,
// checked one edge after each set of operands is applied.
module tb_adder_7sd;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sayi1;
  logic [5:0] sayi2;
  logic [1:0] A, B, C, D, E, F, G;
  logic       DP;

  int tests = 0;
  int fails = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  string pats[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  adder_7sd dut (
    .clk   (clk),
    .rst   (rst),
    .sayi1 (sayi1),
    .sayi2 (sayi2),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D),
    .E     (E),
    .F     (F),
    .G     (G),
    .DP    (DP)
  );

  always #5 clk = ~clk;

  function automatic bit is_lit(int digit, int seg_idx);
    string p;
    byte   letter;
    p = pats[digit];
    letter = byte'(8'd97 + seg_idx);
    for (int k = 0; k < p.len(); k++)
      if (p[k] == letter) return 1'b1;
    return 1'b0;
  endfunction

  // Packed as {A,B,C,D,E,F,G,DP}, each segment pair {tens, units}.
  function automatic logic [14:0] model(bit r, logic [5:0] a, logic [5:0] b);
    int s, m, t, u;
    logic [14:0] res;
    if (r) return 15'h7FFF;
    s = int'($signed(a)) + int'($signed(b));
    m = (s < 0) ? -s : s;
    t = m / 10;
    u = m % 10;
    for (int i = 0; i < 7; i++) begin
      res[14 - 2*i]     = !((t != 0) && is_lit(t, i));
      res[14 - 2*i - 1] = !is_lit(u, i);
    end
    res[0] = !(s < 0);
    return res;
  endfunction

  task automatic step(input bit r, input int a, input int b, input string tag);
    logic [14:0] got, exp;
    string       t;
    rst   = r;
    sayi1 = 6'(a);
    sayi2 = 6'(b);
    exp_q.push_back(model(r, 6'(a), 6'(b)));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    got = {A, B, C, D, E, F, G, DP};
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard empty got=%h", tag, got);
    end else begin
      exp = exp_q.pop_front();
      t   = tag_q.pop_front();
      assert (got === exp) else begin
        fails++;
        $error("FAIL %s got=%h expected=%h", t, got, exp);
      end
    end
  endtask

  initial begin
    step(1, 8, 20, "reset_hold1");
    step(1, 8, 20, "reset_hold2");
    step(0, 8, 20, "release_8p20");
    step(0, 25, 18, "25p18");
    step(0, 8, -20, "8m20");
    step(0, 13, -2, "13m2");
    step(0, -32, -32, "m32m32");
    step(0, 31, 31, "31p31");
    step(0, 5, -5, "zero");
    step(0, -3, 0, "m3");
    step(1, 31, 31, "reset_mid");
    step(0, -7, -3, "after_reset_m10");
    step(0, 0, 0, "zero_zero");
    step(0, 9, 0, "nine");
    step(0, -1, -9, "m10");
    for (int i = 0; i < 24; i++)
      step(0, int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 63)) - 32,
           $sformatf("latency_%0d", i));
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_leftover count=%0d expected=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
